// File: rtl/bcd_score_counter_if.sv
// Bus bundle between the keystroke-compare logic, the BCD score counter and the
// seven-segment decoder.
interface bcd_score_counter_if #(
    parameter int DIGITS = 4
);
    logic                  clear;
    logic                  inc;
    logic [4*DIGITS-1:0]   score;
    logic                  overflow;
    logic [3:0]            digit_val;
    logic [DIGITS-1:0]     digit_sel;
    logic                  digit_blank;

    modport master (
        output clear, inc,
        input  score, overflow, digit_val, digit_sel, digit_blank
    );

    modport slave (
        input  clear, inc,
        output score, overflow, digit_val, digit_sel, digit_blank
    );
endinterface

// File: rtl/bcd_score_counter.sv
// Saturating packed-BCD keystroke score counter with a time-multiplexed,
// leading-zero-blanking digit scanner for the seven-segment display.
module bcd_score_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_score_counter_if.slave    bus
);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [4*DIGITS-1:0] score_r;
    logic                overflow_r;
    logic [CNT_W-1:0]    scan_cnt_r;
    logic [IDX_W-1:0]    digit_idx_r;
    logic [DIGITS-1:0]   digit_sel_r;
    logic [4*DIGITS-1:0] score_next_s;
    logic                full_s;
    logic [3:0]          digit_val_s;
    logic                digit_blank_s;

    // Ripple +1 in BCD: a nine receiving a carry wraps to zero and passes it up.
    function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] val);
        logic [4*DIGITS-1:0] res;
        logic                carry;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry && (val[4*i +: 4] == 4'd9)) begin
                res[4*i +: 4] = 4'd0;
            end else if (carry) begin
                res[4*i +: 4] = val[4*i +: 4] + 4'd1;
                carry         = 1'b0;
            end else begin
                res[4*i +: 4] = val[4*i +: 4];
            end
        end
        return res;
    endfunction

    assign score_next_s = bcd_inc(score_r);
    assign full_s       = (score_r == {DIGITS{4'd9}});

    // Score and sticky overflow; clear outranks inc, full scale drops the increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_r    <= '0;
            overflow_r <= 1'b0;
        end else if (bus.clear) begin
            score_r    <= '0;
            overflow_r <= 1'b0;
        end else if (bus.inc && full_s) begin
            overflow_r <= 1'b1;
        end else if (bus.inc) begin
            score_r    <= score_next_s;
        end else begin
            score_r    <= score_r;
        end
    end

    // Free-running scan divider; index and one-hot select advance together on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= '0;
            digit_sel_r <= DIGITS'(1);
        end else if (scan_cnt_r == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_r  <= '0;
            digit_idx_r <= (digit_idx_r == IDX_W'(DIGITS - 1)) ? '0 : digit_idx_r + IDX_W'(1);
            digit_sel_r <= {digit_sel_r[DIGITS-2:0], digit_sel_r[DIGITS-1]};
        end else begin
            scan_cnt_r  <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Selected nibble and blanking: a digit is blank only if it and everything above it is zero.
    always_comb begin
        digit_val_s   = 4'd0;
        digit_blank_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            digit_val_s   = (digit_idx_r == IDX_W'(i)) ? score_r[4*i +: 4] : digit_val_s;
            digit_blank_s = (digit_idx_r == IDX_W'(i)) ?
                            ((i != 0) && ((score_r >> (4*i)) == '0)) : digit_blank_s;
        end
    end

    assign bus.score       = score_r;
    assign bus.overflow    = overflow_r;
    assign bus.digit_sel   = digit_sel_r;
    assign bus.digit_val   = digit_val_s;
    assign bus.digit_blank = digit_blank_s;
endmodule
